// File: rtl/dcache_qspi_port_if.sv
// Cache line-transfer handshake plus QSPI pad signals for dcache_qspi_port.
// The master side is the cache / pad ring; the slave side is the port itself.
interface dcache_qspi_port_if #(
  parameter int PA          = 22,
  parameter int LINE_LENGTH = 4
);
  localparam int TW = PA - $clog2(LINE_LENGTH);

  // cache side
  logic          req;
  logic          push;
  logic          pull;
  logic [TW-1:0] tag;
  logic [3:0]    dwrite;
  logic [3:0]    dread;
  logic          wstrobe_d;
  logic          rstrobe_d;
  logic          busy;
  logic          done;
  // PSRAM pad side
  logic          q_cs_n;
  logic          q_sck_en;
  logic [3:0]    q_out;
  logic          q_oe;
  logic [3:0]    q_in;

  modport master (
    output req, push, pull, tag, dwrite, q_in,
    input  dread, wstrobe_d, rstrobe_d, busy, done,
           q_cs_n, q_sck_en, q_out, q_oe
  );

  modport slave (
    input  req, push, pull, tag, dwrite, q_in,
    output dread, wstrobe_d, rstrobe_d, busy, done,
           q_cs_n, q_sck_en, q_out, q_oe
  );
endinterface

// File: rtl/dcache_qspi_port.sv
// Memory-side responder for the data cache: turns each push (write-back) or
// pull (line fill) into one quad-SPI PSRAM transaction and streams nibbles
// to/from the cache with contiguous strobes.
module dcache_qspi_port #(
  parameter int          LINE_LENGTH = 4,
  parameter int          PA          = 22,
  parameter int          DUMMY       = 6,
  parameter int          CS_HIGH     = 2,
  parameter logic [7:0]  CMD_RD      = 8'hEB,
  parameter logic [7:0]  CMD_WR      = 8'h38
) (
  input  logic              clk,
  input  logic              reset,
  dcache_qspi_port_if.slave bus
);

  localparam int OFFW = $clog2(LINE_LENGTH);
  localparam int NIB  = 2 * LINE_LENGTH;
  localparam int CMAX = (NIB > 16) ? NIB : 16;
  localparam int CW   = $clog2(CMAX) + 1;

  localparam logic [CW-1:0] C_ONE       = CW'(1);
  localparam logic [CW-1:0] C_CMD_LAST  = CW'(1);
  localparam logic [CW-1:0] C_ADDR_LAST = CW'(5);
  localparam logic [CW-1:0] C_DATA_LAST = CW'(NIB - 1);
  localparam logic [CW-1:0] C_DUMMY_LEN = CW'(DUMMY);
  localparam logic [CW-1:0] C_CSH_WR    = CW'(CS_HIGH);
  localparam logic [CW-1:0] C_CSH_RD    = CW'(CS_HIGH - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_CMD, S_ADDR, S_DUM, S_DATA, S_DRAIN, S_CSH
  } state_t;

  state_t        r_state;
  state_t        w_next;
  logic [CW-1:0] r_cnt;
  logic          r_wr;
  logic [27:0]   r_sh;
  logic [3:0]    r_q_out;
  logic [3:0]    r_dread_p1;
  logic          r_vld_p1;

  logic          w_start;
  logic [7:0]    w_cmd;
  logic [PA-1:0] w_line_addr;
  logic [23:0]   w_addr;
  logic          w_cs_n;
  logic          w_sck_en;
  logic          w_oe;
  logic          w_rstrobe;
  logic          w_done;

  assign w_start     = (r_state == S_IDLE) && bus.req && (bus.push || bus.pull);
  assign w_cmd       = bus.push ? CMD_WR : CMD_RD;
  assign w_line_addr = {bus.tag, OFFW'(0)};
  assign w_addr      = 24'(w_line_addr);

  // State register and per-state cycle counter (counter restarts on every state change)
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_next;
      r_cnt   <= (w_next != r_state || w_next == S_IDLE) ? '0 : r_cnt + C_ONE;
    end
  end

  // Next-state decode; read CS-high time counts DRAIN as its first cycle
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (w_start) w_next = S_CMD;
      S_CMD:   if (r_cnt == C_CMD_LAST) w_next = S_ADDR;
      S_ADDR:  if (r_cnt == C_ADDR_LAST) w_next = (r_wr || DUMMY == 0) ? S_DATA : S_DUM;
      S_DUM:   if (r_cnt + C_ONE == C_DUMMY_LEN) w_next = S_DATA;
      S_DATA:  if (r_cnt == C_DATA_LAST) w_next = r_wr ? S_CSH : S_DRAIN;
      S_DRAIN: w_next = (CS_HIGH > 1) ? S_CSH : S_IDLE;
      S_CSH:   if (r_cnt + C_ONE == (r_wr ? C_CSH_WR : C_CSH_RD)) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Pad and strobe outputs decoded from the current state
  always_comb begin
    w_cs_n    = 1'b1;
    w_sck_en  = 1'b0;
    w_oe      = 1'b0;
    w_rstrobe = 1'b0;
    w_done    = 1'b0;
    case (r_state)
      S_CMD: begin
        w_cs_n   = 1'b0;
        w_sck_en = 1'b1;
        w_oe     = 1'b1;
      end
      S_ADDR: begin
        w_cs_n    = 1'b0;
        w_sck_en  = 1'b1;
        w_oe      = 1'b1;
        // The last address cycle already pulls nibble 0 out of the cache.
        w_rstrobe = r_wr && (r_cnt == C_ADDR_LAST);
      end
      S_DUM: begin
        w_cs_n   = 1'b0;
        w_sck_en = 1'b1;
      end
      S_DATA: begin
        w_cs_n    = 1'b0;
        w_sck_en  = 1'b1;
        w_oe      = r_wr;
        w_rstrobe = r_wr && (r_cnt != C_DATA_LAST);
        w_done    = r_wr && (r_cnt == C_DATA_LAST);
      end
      S_DRAIN: w_done = !r_wr;
      default: ;
    endcase
  end

  // Direction is latched at start and held until the next IDLE
  always_ff @(posedge clk) begin
    if (reset)        r_wr <= 1'b0;
    else if (w_start) r_wr <= bus.push;
  end

  // Header shifter: command low nibble then six address nibbles, MS first
  always_ff @(posedge clk) begin
    if (w_start)                                r_sh <= {w_cmd[3:0], w_addr};
    else if (r_state == S_CMD || r_state == S_ADDR) r_sh <= {r_sh[23:0], 4'h0};
  end

  // p0 -> p1: q_out register, one cycle ahead of the nibble it presents
  always_ff @(posedge clk) begin
    if (reset) begin
      r_q_out <= 4'h0;
    end else begin
      case (r_state)
        S_IDLE:  r_q_out <= w_start ? w_cmd[7:4] : 4'h0;
        S_CMD:   r_q_out <= r_sh[27:24];
        S_ADDR:  r_q_out <= (r_cnt == C_ADDR_LAST) ? (r_wr ? bus.dwrite : 4'h0) : r_sh[27:24];
        S_DATA:  r_q_out <= (r_wr && r_cnt != C_DATA_LAST) ? bus.dwrite : 4'h0;
        default: r_q_out <= 4'h0;
      endcase
    end
  end

  // p0 -> p1: read capture; valid follows each sampled nibble by one cycle
  always_ff @(posedge clk) begin
    if (reset) begin
      r_vld_p1   <= 1'b0;
      r_dread_p1 <= 4'h0;
    end else begin
      r_vld_p1 <= (r_state == S_DATA) && !r_wr;
      if ((r_state == S_DATA) && !r_wr) r_dread_p1 <= bus.q_in;
    end
  end

  assign bus.dread     = r_dread_p1;
  assign bus.wstrobe_d = r_vld_p1;
  assign bus.rstrobe_d = w_rstrobe;
  assign bus.busy      = (r_state != S_IDLE);
  assign bus.done      = w_done;
  assign bus.q_cs_n    = w_cs_n;
  assign bus.q_sck_en  = w_sck_en;
  assign bus.q_out     = r_q_out;
  assign bus.q_oe      = w_oe;

endmodule

// File: tb/tb_dcache_qspi_port.sv
// Directed bench for dcache_qspi_port: read/write framing, strobe timing,
// push priority, mid-transaction reset, req gating and the zero-dummy build.
module tb_dcache_qspi_port;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  dcache_qspi_port_if #(.PA(22), .LINE_LENGTH(4)) bus  ();
  dcache_qspi_port_if #(.PA(22), .LINE_LENGTH(4)) bus0 ();

  dcache_qspi_port #(.DUMMY(6)) dut    (.clk(clk), .reset(reset), .bus(bus));
  dcache_qspi_port #(.DUMMY(0)) dut_d0 (.clk(clk), .reset(reset), .bus(bus0));

  // Cache offset model: advances on rstrobe_d, clears on any gap; dwrite = offset^1
  logic [2:0] r_off;
  always @(posedge clk) begin
    if (reset || !bus.rstrobe_d) r_off <= 3'd0;
    else                         r_off <= r_off + 3'd1;
  end
  assign bus.dwrite = {1'b0, r_off} ^ 4'h1;

  logic [3:0] exp_hdr_rd [8];
  logic [3:0] exp_hdr_wr [8];
  logic [3:0] exp_dat_wr [8];

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle(input string name);
    for (int k = 0; k < 60 && bus.busy; k++) step();
    chk(name, 32'(bus.busy), 32'h0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    int found, nstb, ndone, first, last;
    exp_hdr_rd = '{4'hE, 4'hB, 4'h0, 4'h4, 4'h8, 4'hD, 4'h1, 4'h4};
    exp_hdr_wr = '{4'h3, 4'h8, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h4};
    exp_dat_wr = '{4'h1, 4'h0, 4'h3, 4'h2, 4'h5, 4'h4, 4'h7, 4'h6};

    reset = 1'b1;
    bus.req = 0;  bus.push = 0;  bus.pull = 0;  bus.tag = '0;  bus.q_in = '0;
    bus0.req = 0; bus0.push = 0; bus0.pull = 0; bus0.tag = '0; bus0.q_in = '0;
    bus0.dwrite = '0;
    step(); step();

    // Reset state
    chk("rst_cs_n",    32'(bus.q_cs_n),    32'h1);
    chk("rst_busy",    32'(bus.busy),      32'h0);
    chk("rst_done",    32'(bus.done),      32'h0);
    chk("rst_wstrobe", 32'(bus.wstrobe_d), 32'h0);
    chk("rst_rstrobe", 32'(bus.rstrobe_d), 32'h0);
    chk("rst_q_out",   32'(bus.q_out),     32'h0);
    chk("rst_q_oe",    32'(bus.q_oe),      32'h0);
    chk("rst_sck_en",  32'(bus.q_sck_en),  32'h0);
    chk("rst_dread",   32'(bus.dread),     32'h0);
    reset = 1'b0;
    step();

    // Pull, tag 12345, six dummy cycles; start in this cycle
    bus.req = 1; bus.pull = 1; bus.tag = 20'h12345;
    for (int c = 1; c <= 8; c++) begin
      step();
      if (c == 1) bus.pull = 0;
      chk("rd_hdr_nibble", 32'(bus.q_out),  32'(exp_hdr_rd[c-1]));
      chk("rd_hdr_cs_n",   32'(bus.q_cs_n), 32'h0);
      chk("rd_hdr_oe",     32'(bus.q_oe),   32'h1);
    end
    for (int c = 9; c <= 14; c++) begin
      step();
      chk("rd_dummy_oe",  32'(bus.q_oe),      32'h0);
      chk("rd_dummy_sck", 32'(bus.q_sck_en),  32'h1);
      chk("rd_dummy_wst", 32'(bus.wstrobe_d), 32'h0);
    end
    for (int j = 0; j < 8; j++) begin
      step();
      bus.q_in = 4'(j + 1);
      chk("rd_data_wstrobe", 32'(bus.wstrobe_d), 32'(j > 0));
      if (j > 0) chk("rd_data_dread", 32'(bus.dread), 32'(j));
      chk("rd_data_done", 32'(bus.done), 32'h0);
      chk("rd_data_oe",   32'(bus.q_oe), 32'h0);
    end
    step();
    chk("rd_drain_wstrobe", 32'(bus.wstrobe_d), 32'h1);
    chk("rd_drain_dread",   32'(bus.dread),     32'h8);
    chk("rd_drain_done",    32'(bus.done),      32'h1);
    chk("rd_drain_cs_n",    32'(bus.q_cs_n),    32'h1);
    chk("rd_drain_sck",     32'(bus.q_sck_en),  32'h0);
    step();
    chk("rd_csh_wstrobe", 32'(bus.wstrobe_d), 32'h0);
    chk("rd_csh_done",    32'(bus.done),      32'h0);
    chk("rd_csh_busy",    32'(bus.busy),      32'h1);
    step();
    chk("rd_idle_busy",   32'(bus.busy),      32'h0);

    // Push, tag 1, cache returns offset^1
    bus.push = 1; bus.tag = 20'h00001;
    for (int c = 1; c <= 8; c++) begin
      step();
      if (c == 1) bus.push = 0;
      chk("wr_hdr_nibble", 32'(bus.q_out),     32'(exp_hdr_wr[c-1]));
      chk("wr_hdr_rstrobe", 32'(bus.rstrobe_d), 32'(c == 8));
      chk("wr_hdr_oe",     32'(bus.q_oe),      32'h1);
    end
    for (int c = 9; c <= 16; c++) begin
      step();
      chk("wr_data_nibble",  32'(bus.q_out),     32'(exp_dat_wr[c-9]));
      chk("wr_data_rstrobe", 32'(bus.rstrobe_d), 32'(c < 16));
      chk("wr_data_done",    32'(bus.done),      32'(c == 16));
      chk("wr_data_oe",      32'(bus.q_oe),      32'h1);
      chk("wr_data_wstrobe", 32'(bus.wstrobe_d), 32'h0);
    end
    step();
    chk("wr_csh_rstrobe", 32'(bus.rstrobe_d), 32'h0);
    chk("wr_csh_done",    32'(bus.done),      32'h0);
    chk("wr_csh_cs_n",    32'(bus.q_cs_n),    32'h1);
    wait_idle("wr_end_idle");

    // Push and pull together: write first, read CS_HIGH+1 cycles after done
    bus.push = 1; bus.pull = 1; bus.tag = 20'h00002;
    step();
    chk("both_first_cmd_wr", 32'(bus.q_out), 32'h3);
    found = 0;
    for (int k = 0; k < 30 && found == 0; k++) begin
      step();
      if (bus.done) found = 1;
    end
    chk("both_wr_done_seen", 32'(found), 32'h1);
    bus.push = 0;
    step();
    chk("both_gap1_cs_n", 32'(bus.q_cs_n), 32'h1);
    chk("both_gap1_busy", 32'(bus.busy),   32'h1);
    step();
    chk("both_gap2_cs_n", 32'(bus.q_cs_n), 32'h1);
    chk("both_gap2_busy", 32'(bus.busy),   32'h1);
    step();
    chk("both_gap3_cs_n", 32'(bus.q_cs_n), 32'h1);
    chk("both_gap3_busy", 32'(bus.busy),   32'h0);
    step();
    chk("both_rd_cs_n",   32'(bus.q_cs_n), 32'h0);
    chk("both_rd_cmd",    32'(bus.q_out),  32'hE);
    bus.pull = 0;
    wait_idle("both_rd_end_idle");

    // Reset during read DATA cycle 3
    bus.pull = 1; bus.tag = 20'h00003;
    for (int c = 1; c <= 18; c++) begin
      step();
      if (c == 1) bus.pull = 0;
      bus.q_in = 4'(c);
    end
    chk("rstmid_pre_wstrobe", 32'(bus.wstrobe_d), 32'h1);
    reset = 1'b1;
    step();
    chk("rstmid_cs_n",    32'(bus.q_cs_n),    32'h1);
    chk("rstmid_wstrobe", 32'(bus.wstrobe_d), 32'h0);
    chk("rstmid_busy",    32'(bus.busy),      32'h0);
    chk("rstmid_done",    32'(bus.done),      32'h0);
    reset = 1'b0;
    step();
    bus.pull = 1;
    nstb = 0; ndone = 0; first = -1; last = -1;
    for (int c = 1; c <= 30; c++) begin
      step();
      if (c == 1) bus.pull = 0;
      bus.q_in = 4'(c);
      if (bus.wstrobe_d) begin
        nstb++;
        if (first < 0) first = c;
        last = c;
      end
      if (bus.done) ndone++;
    end
    chk("rstmid_after_strobes", 32'(nstb),             32'h8);
    chk("rstmid_after_contig",  32'(last - first + 1), 32'h8);
    chk("rstmid_after_first",   32'(first),            32'd16);
    chk("rstmid_after_done",    32'(ndone),            32'h1);

    // req low blocks a pending pull
    bus.req = 0; bus.pull = 1;
    for (int c = 0; c < 20; c++) begin
      step();
      chk("reqlow_cs_n", 32'(bus.q_cs_n), 32'h1);
      chk("reqlow_busy", 32'(bus.busy),   32'h0);
    end
    bus.req = 1;
    step();
    chk("reqhi_busy",  32'(bus.busy),   32'h1);
    chk("reqhi_cs_n",  32'(bus.q_cs_n), 32'h0);
    chk("reqhi_cmd",   32'(bus.q_out),  32'hE);
    bus.pull = 0;
    wait_idle("reqhi_end_idle");

    // Zero-dummy build: DATA follows ADDR, first strobe 10 cycles after start
    bus0.req = 1; bus0.pull = 1; bus0.tag = 20'h00005;
    for (int c = 1; c <= 10; c++) begin
      step();
      if (c == 1) bus0.pull = 0;
      if (c >= 9) bus0.q_in = 4'(c);
      chk("d0_wstrobe", 32'(bus0.wstrobe_d), 32'(c == 10));
      if (c == 9) begin
        chk("d0_data_oe",   32'(bus0.q_oe),   32'h0);
        chk("d0_data_cs_n", 32'(bus0.q_cs_n), 32'h0);
      end
    end
    chk("d0_first_dread", 32'(bus0.dread), 32'h9);
    for (int k = 0; k < 40 && bus0.busy; k++) step();
    chk("d0_end_idle", 32'(bus0.busy), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/dcache_qspi_port.md
Name: dcache_qspi_port

Overview:
- Memory-side responder for the data cache line-transfer interface. It services the cache's push (write-back) and pull (line fill) requests.
- Converts each request into a single QSPI (4-bit) transaction to external PSRAM.
- Sources the nibble stream into the cache (dread/wstrobe_d) and consumes the cache's outgoing nibbles (dwrite/rstrobe_d) with the contiguous strobe timing the cache's offset counter requires.
- Sits between dcache and the pad ring.

Parameters:
- LINE_LENGTH, 4, cache line length in bytes; a transfer is 2*LINE_LENGTH nibbles.
- PA, 22, physical address width.
- DUMMY, 6, read dummy cycles between address and data, range 0..15.
- CS_HIGH, 2, minimum cycles q_cs_n stays high between transactions, range 1..7.
- CMD_RD, 8'hEB, quad read command.
- CMD_WR, 8'h38, quad write command.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- req  in  1  a CPU load/store is in flight, so push/pull are meaningful
- push  in  1  cache needs this line written back
- pull  in  1  cache needs this line filled
- tag  in  PA-log2(LINE_LENGTH)  line address from cache
- dwrite  in  4  cache's outgoing nibble for its current offset
- dread  out  4  nibble into cache
- wstrobe_d  out  1  dread valid; cache advances offset and stores
- rstrobe_d  out  1  cache advances its read offset
- busy  out  1  transaction in progress (state != IDLE)
- done  out  1  one-cycle pulse at end of data phase
- q_cs_n  out  1  PSRAM chip select, active low
- q_sck_en  out  1  pad clock enable; one nibble per clk while high
- q_out  out  4  nibble to PSRAM
- q_oe  out  1  drive q_out onto pads
- q_in  in  4  nibble from PSRAM

Behaviour:
- Reset values: q_cs_n=1; all other outputs 0; state IDLE; counters 0.
- Byte address = {tag, log2(LINE_LENGTH) zero bits}, zero-extended to 24 bits. tag and direction are latched at start; later changes are ignored until IDLE.
- IDLE: start when req && (push || pull).
  - push has priority and selects a write; otherwise the transaction is a read.
  - On start: latch, next state CMD.
- CMD, 2 cycles, then ADDR, 6 cycles.
  - q_cs_n=0, q_sck_en=1, q_oe=1.
  - q_out is registered and presents command nibbles, then address nibbles, MS nibble first.
- Write path:
  - DATA runs for 2*LINE_LENGTH cycles, with q_out <= dwrite registered.
  - rstrobe_d asserts from the last ADDR cycle through the second-to-last DATA cycle: exactly 2*LINE_LENGTH contiguous cycles. Each cycle registers the cache's current dwrite, so PSRAM receives nibble 0 in DATA cycle 0.
  - done pulses in the final DATA cycle.
- Read path:
  - DUMMY runs for DUMMY cycles with q_oe=0, q_sck_en=1; DUMMY=0 skips the state.
  - DATA runs for 2*LINE_LENGTH cycles with q_oe=0; q_in is sampled each cycle.
  - dread <= q_in, with wstrobe_d asserted the cycle after each sample: 2*LINE_LENGTH contiguous cycles.
  - DRAIN, 1 cycle: q_cs_n=1, q_sck_en=0; carries the last wstrobe_d. done pulses with the last wstrobe_d.
- CSH: q_cs_n=1, q_sck_en=0 for CS_HIGH cycles (read: including DRAIN), then IDLE.
  - A new start is taken no earlier than the first IDLE cycle.
  - A back-to-back push then pull costs CS_HIGH+1 cycles of gap.
- Strobe invariants:
  - wstrobe_d and rstrobe_d are never both high.
  - Neither is ever asserted outside its contiguous run; the cache resets its offset on any strobe gap.
- reset mid-transaction: next cycle IDLE, q_cs_n=1, strobes 0, no done. The cache's offset self-clears because strobes drop.
- push/pull deasserting mid-transaction is ignored. req low in IDLE blocks any start.
- busy is high from the cycle after start through the last CSH cycle.

Test Plan:
- Pull, tag=20'h12345, DUMMY=6 -> q_out carries E,B,0,4,8,D,1,4 on consecutive cycles. q_in is fed 1..8, and dread shows 1..8 on 8 contiguous wstrobe_d cycles. done coincides with the 8th strobe. First wstrobe_d occurs 1+2+6+6+1 = 16 cycles after start.
- Push, tag=20'h00001, cache model returns dwrite=offset^1 per its offset -> q_out carries 3,8,0,0,0,0,0,4 then 1,0,3,2,5,4,7,6. rstrobe_d is high for exactly 8 contiguous cycles, starting in the ADDR nibble-6 cycle. q_oe is 1 throughout.
- push and pull both high with req=1 -> a write transaction is issued first. After push drops, the read starts exactly CS_HIGH+1 cycles after the write's done. q_cs_n is high for >= CS_HIGH cycles between.
- reset asserted in read DATA cycle 3 -> the next cycle shows q_cs_n=1, wstrobe_d=0, busy=0, and no done. A subsequent pull completes normally with 8 strobes.
- req=0 with pull=1 for 20 cycles -> q_cs_n stays 1 and busy stays 0. Setting req=1 starts CMD on the next cycle.
- DUMMY=0 pull -> DATA immediately follows ADDR. The first wstrobe_d occurs 10 cycles after start.
